// File: rtl/dct_pkg.sv
// Shared definitions for the dct3 split/merge stages: default sizes, slot order
// of a 4-sample group and the merge-stage state type.
package dct_pkg;

  localparam int unsigned W_DEF                = 8;
  localparam int unsigned GROUPS_PER_BLOCK_DEF = 16;

  localparam logic [1:0] SLOT_O1 = 2'd0;
  localparam logic [1:0] SLOT_E1 = 2'd1;
  localparam logic [1:0] SLOT_O2 = 2'd2;
  localparam logic [1:0] SLOT_E2 = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/dct3_merge.sv
// Re-interleaves an (o1,o2,e1,e2) group into natural order b,d,f,h and streams it
// one sample per clock; out_last flags the final sample of each 8x8 block.
module dct3_merge
  import dct_pkg::*;
#(
  parameter int unsigned W                = W_DEF,
  parameter int unsigned GROUPS_PER_BLOCK = GROUPS_PER_BLOCK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] o1,
  input  logic [W-1:0] e1,
  input  logic [W-1:0] o2,
  input  logic [W-1:0] e2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int unsigned   CW       = (GROUPS_PER_BLOCK > 1) ? $clog2(GROUPS_PER_BLOCK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GROUPS_PER_BLOCK - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  buf_q [4];
  logic [1:0]    idx_q;
  logic [1:0]    idx_nx;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          adv;
  logic          at_end;

  always_comb begin
    at_end   = (idx_q == SLOT_E2);
    in_ready = (state_q == ST_IDLE) || (at_end && out_ready);
    accept   = in_valid && in_ready;
    adv      = (state_q == ST_SHIFT) && out_ready;
    idx_nx   = idx_q + 2'd1;
    state_d  = state_q;
    if (accept) begin
      state_d = ST_SHIFT;
    end else if (adv && at_end) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_valid = (state_q == ST_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      if (adv && at_end) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
      // A new group at the idx==3 hand-off takes priority, giving a bubble-free o1.
      if (accept) begin
        buf_q[SLOT_O1] <= o1;
        buf_q[SLOT_E1] <= e1;
        buf_q[SLOT_O2] <= o2;
        buf_q[SLOT_E2] <= e2;
        out_data       <= o1;
        idx_q          <= SLOT_O1;
        out_last       <= 1'b0;
      end else if (adv && !at_end) begin
        idx_q    <= idx_nx;
        out_data <= buf_q[idx_nx];
        out_last <= (idx_nx == SLOT_E2) && (cnt_q == CNT_LAST);
      end else if (adv) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct3_merge.sv
// Bench for dct3_merge: directed phases plus randomized groups, checked against
// a sample queue and a running sample count for block framing.
module tb_dct3_merge;
  import dct_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned G = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] o1 = '0, e1 = '0, o2 = '0, e2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;

  int           n_chk = 0;
  int           n_pass = 0;
  logic         mon_en = 1'b0;
  logic         rnd_en = 1'b0;
  logic [W-1:0] exp_q[$];
  int unsigned  k = 0;

  always #5 clk = ~clk;

  dct3_merge #(.W(W), .GROUPS_PER_BLOCK(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .o1(o1), .e1(e1), .o2(o2), .e2(e2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: every accepted group appends o1,e1,o2,e2; output stays valid while
  // samples are owed; sample k (since reset) is last when k % 64 == 63.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, in_ready},
            {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)});
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        check("last", {31'd0, out_last}, {31'd0, (k % (4 * G)) == (4 * G - 1)});
        k++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(o1);
        exp_q.push_back(e1);
        exp_q.push_back(o2);
        exp_q.push_back(e2);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_group(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
    int unsigned t = 0;
    o1 = a; e1 = b; o2 = c; e2 = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    o1 = W'($urandom); e1 = W'($urandom); o2 = W'($urandom); e2 = W'($urandom);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values, during and after reset
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_data", {24'd0, out_data}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // single group, then idle with the last value held
    out_ready = 1'b1;
    send_group(8'h11, 8'h22, 8'h33, 8'h44);
    drain();
    @(negedge clk);
    check("idle_hold", {24'd0, out_data}, 32'h44);

    // backpressure while 22 is shown
    send_group(8'h11, 8'h22, 8'h33, 8'h44);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", {24'd0, out_data}, 32'h22);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_resume", {24'd0, out_data}, 32'h33);
    drain();

    // back-to-back groups with in_valid held
    send_group(8'h01, 8'h02, 8'h03, 8'h04);
    send_group(8'h05, 8'h06, 8'h07, 8'h08);
    drain();

    // block framing with random backpressure and gaps: 17 incrementing groups, then random
    rnd_en = 1'b1;
    for (int g = 0; g < 30; g++) begin
      if (g < 17)
        send_group(W'(4 * g), W'(4 * g + 1), W'(4 * g + 2), W'(4 * g + 3));
      else
        send_group(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_en = 1'b0;
    #1 out_ready = 1'b1;
    drain();

    // reset in the middle of a group
    send_group(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_data", {24'd0, out_data}, 32'd0);
    check("async_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    k = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int g = 0; g < 17; g++) begin
      send_group(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    rnd_en = 1'b0;
    #1 out_ready = 1'b1;
    drain();
    check("sample_count", k, 32'd68);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
